// File: rtl/mod_exp_ct.sv
// Constant-time modular exponentiator: result = base^exponent mod modulo,
// right-to-left square-and-multiply on two bit-serial interleaved multipliers.
`timescale 1ns/1ps
module mod_exp_ct #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] modulo,
  input  logic [WIDTH-1:0] exponent,
  output logic             busy,
  output logic             finish,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = WIDTH + 2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RED  = 3'd1;
  localparam logic [2:0] S_EXP  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]       state;
  logic [WIDTH-1:0] base_r, mod_r, exp_r;
  logic [WIDTH-1:0] r_reg, b_reg;
  logic [AW-1:0]    acc1, acc2;
  logic [CW-1:0]    cnt, step;

  logic [CW-1:0]    idx;
  logic [WIDTH-1:0] one_m, b1;
  logic             a1;
  logic [AW-1:0]    nxt1, nxt2;

  // One interleaved step: acc < m and b < m keep the sum below 3m,
  // so two conditional subtractions always restore acc < m.
  function automatic logic [AW-1:0] mm_step(input logic [AW-1:0] acc,
                                            input logic abit,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] m);
    logic [AW-1:0] t;
    logic [AW-1:0] mm;
    mm = {2'b00, m};
    t  = (acc << 1) + (abit ? {2'b00, b} : '0);
    if (t >= mm) t = t - mm;
    if (t >= mm) t = t - mm;
    return t;
  endfunction

  always_comb begin
    idx   = LAST - cnt;
    one_m = (mod_r == WIDTH'(1)) ? '0 : WIDTH'(1);
    a1    = (state == S_RED) ? base_r[idx] : r_reg[idx];
    b1    = (state == S_RED) ? one_m : b_reg;
    nxt1  = mm_step(acc1, a1, b1, mod_r);
    nxt2  = mm_step(acc2, b_reg[idx], b_reg, mod_r);
  end

  assign busy = (state == S_RED) || (state == S_EXP) || (state == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      base_r <= '0;
      mod_r  <= '0;
      exp_r  <= '0;
      r_reg  <= '0;
      b_reg  <= '0;
      acc1   <= '0;
      acc2   <= '0;
      cnt    <= '0;
      step   <= '0;
      finish <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      finish <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_r <= base;
            mod_r  <= modulo;
            exp_r  <= exponent;
            acc1   <= '0;
            acc2   <= '0;
            cnt    <= '0;
            step   <= '0;
            if (modulo == '0) begin
              state <= S_ERR;
            end else begin
              err   <= 1'b0;
              state <= S_RED;
            end
          end
        end
        S_ERR: begin
          finish <= 1'b1;
          err    <= 1'b1;
          result <= '0;
          state  <= S_IDLE;
        end
        S_RED: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (cnt == LAST) begin
            b_reg <= nxt1[WIDTH-1:0];
            r_reg <= one_m;
            acc1  <= '0;
            cnt   <= '0;
            state <= S_EXP;
          end else begin
            acc1 <= nxt1;
            cnt  <= cnt + 1'b1;
          end
        end
        S_EXP: begin
          // Both products run every step; the exponent bit only selects
          // whether R takes the new value, so timing never depends on data.
          if (abort) begin
            state <= S_IDLE;
          end else if (cnt == LAST) begin
            if (exp_r[step]) r_reg <= nxt1[WIDTH-1:0];
            b_reg <= nxt2[WIDTH-1:0];
            acc1  <= '0;
            acc2  <= '0;
            cnt   <= '0;
            if (step == LAST) state <= S_DONE;
            else              step  <= step + 1'b1;
          end else begin
            acc1 <= nxt1;
            acc2 <= nxt2;
            cnt  <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            result <= r_reg;
            finish <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_ct.sv
// Scoreboard bench for mod_exp_ct: driver queues expected results at each
// accepted start, a negedge monitor compares them when finish pulses.
`timescale 1ns/1ps
module tb_mod_exp_ct;
  localparam int W   = 32;
  localparam int LAT = (W + 1) * W + 1;

  logic         clk = 1'b0;
  logic         reset, start, abort;
  logic [W-1:0] base, modulo, exponent;
  logic         busy, finish, err;
  logic [W-1:0] result;

  always #5 clk = ~clk;

  mod_exp_ct #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base(base), .modulo(modulo), .exponent(exponent),
    .busy(busy), .finish(finish), .err(err), .result(result)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    longint       t_acc;
    int           lat;
  } exp_t;

  exp_t         sbq[$];
  int           n_vec = 0;
  int           n_bad = 0;
  logic [W-1:0] last_res = '0;
  logic         last_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: left-to-right exponentiation with plain 64-bit arithmetic.
  function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [W-1:0] m,
                                              input logic [W-1:0] e);
    longint unsigned r, bb, mm;
    if (m == 0) return '0;
    mm = longint'(m);
    bb = longint'(b) % mm;
    r  = 1 % mm;
    for (int i = W - 1; i >= 0; i--) begin
      r = (r * r) % mm;
      if (e[i]) r = (r * bb) % mm;
    end
    return W'(r);
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b0 && finish === 1'b1) begin
      exp_t e;
      if (sbq.size() == 0) begin
        check("unexpected_finish", 64'd1, 64'd0);
      end else begin
        e = sbq.pop_front();
        check("result", result, e.res);
        check("err", err, e.err);
        check("latency", ($time - 5 - e.t_acc) / 10, e.lat);
      end
    end
  end

  task automatic issue(input logic [W-1:0] b, input logic [W-1:0] m, input logic [W-1:0] e,
                       input bit track, input bit now);
    exp_t x;
    if (!now) @(negedge clk);
    base = b; modulo = m; exponent = e; start = 1'b1;
    @(posedge clk);
    if (track) begin
      x.res   = ref_modexp(b, m, e);
      x.err   = (m == 0);
      x.t_acc = $time;
      x.lat   = (m == 0) ? 1 : LAT;
      sbq.push_back(x);
      last_res = x.res;
      last_err = x.err;
    end
    @(negedge clk);
    start = 1'b0;
    base = $urandom; modulo = $urandom; exponent = $urandom;
    check("busy_after_accept", busy, (m != 0));
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < LAT + 20; i++) begin
      @(negedge clk);
      if (finish === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("finish_timeout", 64'd0, 64'd1);
  endtask

  task automatic run(input logic [W-1:0] b, input logic [W-1:0] m, input logic [W-1:0] e,
                     input bit now);
    issue(b, m, e, 1'b1, now);
    wait_done();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] rb, rm, re;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    base = '0; modulo = '0; exponent = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_finish", finish, 0);
    check("reset_err", err, 0);
    check("reset_result", result, 0);
    reset = 1'b0;

    run(32'd4, 32'd497, 32'd13, 1'b0);
    run(32'd65, 32'd3233, 32'd17, 1'b0);
    run(32'd2790, 32'd3233, 32'd2753, 1'b0);
    run(32'h1234, 32'd1927, 32'd0, 1'b0);
    run(32'd99999, 32'd1, 32'd12345, 1'b0);
    run(32'd5000, 32'd1927, 32'd1, 1'b0);
    run(32'd0, 32'd1927, 32'd7, 1'b0);
    run(32'd77, 32'd0, 32'd5, 1'b0);
    run(32'd3, 32'd7, 32'd5, 1'b0);

    // start while busy must be ignored
    issue(32'd123456, 32'd1000003, 32'd65537, 1'b1, 1'b0);
    repeat (100) @(negedge clk);
    base = 32'd9; modulo = 32'd11; exponent = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // abort mid-operation: no finish, outputs retained
    issue(32'd777, 32'd1009, 32'd999, 1'b0, 1'b0);
    repeat (500) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_result_kept", result, last_res);
    check("abort_err_kept", err, last_err);
    run(32'd11, 32'd13, 32'd7, 1'b0);

    // abort together with start in idle: start wins
    abort = 1'b1;
    issue(32'd2, 32'd1000, 32'd20, 1'b1, 1'b0);
    abort = 1'b0;
    wait_done();

    // asynchronous reset in the middle of exponentiation
    issue(32'd31337, 32'd65521, 32'd4000000000, 1'b0, 1'b0);
    repeat (300) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_finish", finish, 0);
    check("midreset_err", err, 0);
    check("midreset_result", result, 0);
    @(negedge clk);
    reset = 1'b0;

    // back-to-back starts on the finish cycle
    run(32'd7, 32'd101, 32'd50, 1'b0);
    run(32'd8, 32'd103, 32'd51, 1'b1);
    run(32'd9, 32'd0, 32'd52, 1'b1);
    run(32'd10, 32'd107, 32'd53, 1'b1);

    for (int i = 0; i < 30; i++) begin
      rb = $urandom;
      re = $urandom;
      case ($urandom_range(0, 4))
        0:       rm = W'($urandom_range(1, 50));
        1:       rm = (i % 6 == 1) ? '0 : W'(1);
        default: rm = $urandom | 32'h1;
      endcase
      run(rb, rm, re, (i % 2 == 1));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
